// File: rtl/rr_dec_arbiter.sv
// Round-robin arbiter for 16 requesters driving a 4-to-16 decoder: registered index/enable and one-hot grant.
// Optional grant timeout is compiled in with `define RR_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_dec_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:15] req_i,
  input  logic        release_i,
  output logic [3:0]  gnt_w_o,
  output logic        gnt_en_o,
  output logic [0:15] gnt_o,
  output logic        tmo_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  state_t      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  gnt_w_q, gnt_w_d;
  logic        gnt_en_q, gnt_en_d;
  logic [0:15] gnt_q, gnt_d;
  logic        tmo_q, tmo_d;
  logic        timeout;

  // Requests rotated so that position 0 is the requester at ptr_q.
  logic [15:0] req_rot;
  logic [3:0]  pick_off;
  logic [3:0]  pick_idx;

  for (genvar gi = 0; gi < 16; gi++) begin : g_rot
    assign req_rot[gi] = req_i[ptr_q + 4'(gi)];
  end

  always_comb begin
    pick_off = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 4'(i);
    end
  end

  assign pick_idx = ptr_q + pick_off;

`ifdef RR_TIMEOUT_EN
  logic [7:0] hcnt_q, hcnt_d;
  assign timeout = (hcnt_q == 8'(MAX_HOLD - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_w_d  = gnt_w_q;
    gnt_en_d = gnt_en_q;
    gnt_d    = gnt_q;
    tmo_d    = 1'b0;
`ifdef RR_TIMEOUT_EN
    hcnt_d   = hcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d         = GRANT;
          gnt_w_d         = pick_idx;
          gnt_en_d        = 1'b1;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
`ifdef RR_TIMEOUT_EN
          hcnt_d          = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (release_i || !req_i[gnt_w_q] || timeout) begin
          state_d  = IDLE;
          gnt_en_d = 1'b0;
          gnt_d    = '0;
          ptr_d    = gnt_w_q + 4'd1;
          // Timeout is only flagged when nothing else would have ended the grant.
          tmo_d    = timeout && !release_i && req_i[gnt_w_q];
        end else begin
`ifdef RR_TIMEOUT_EN
          if (hcnt_q != 8'hFF) hcnt_d = hcnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 4'd0;
      gnt_w_q  <= 4'd0;
      gnt_en_q <= 1'b0;
      gnt_q    <= '0;
      tmo_q    <= 1'b0;
`ifdef RR_TIMEOUT_EN
      hcnt_q   <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_w_q  <= gnt_w_d;
      gnt_en_q <= gnt_en_d;
      gnt_q    <= gnt_d;
      tmo_q    <= tmo_d;
`ifdef RR_TIMEOUT_EN
      hcnt_q   <= hcnt_d;
`endif
    end
  end

  assign gnt_w_o  = gnt_w_q;
  assign gnt_en_o = gnt_en_q;
  assign gnt_o    = gnt_q;
  assign tmo_o    = tmo_q;

endmodule

// File: tb/tb_rr_dec_arbiter.sv
// Bench for rr_dec_arbiter: directed vector table, timeout/hold sequence, then random traffic
// checked against a scan-and-hold reference model.
module tb_rr_dec_arbiter;

  localparam int MAXH = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [0:15] req;
  logic        rel;
  logic [3:0]  gnt_w;
  logic        gnt_en;
  logic [0:15] gnt;
  logic        tmo;

  int checks = 0;
  int errors = 0;

  rr_dec_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .req_i(req), .release_i(rel),
    .gnt_w_o(gnt_w), .gnt_en_o(gnt_en), .gnt_o(gnt), .tmo_o(tmo)
  );

  always #5 clk = ~clk;

  // Reference model: holder index (-1 = nobody), next scan start, cycles held so far.
  int m_holder, m_ptr, m_w, m_hold;
  bit m_tmo;

  task automatic model_step(input logic rst, input logic [0:15] rq, input logic rl);
    bit to, normal;
    if (rst) begin
      m_holder = -1; m_ptr = 0; m_w = 0; m_hold = 0; m_tmo = 1'b0;
    end else if (m_holder < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < 16; k++) begin
        int idx;
        idx = (m_ptr + k) % 16;
        if (m_holder < 0 && rq[idx]) begin
          m_holder = idx; m_w = idx; m_hold = 1;
        end
      end
    end else begin
      to     = TO && (m_hold >= MAXH);
      normal = rl || !rq[m_holder];
      m_tmo  = 1'b0;
      if (normal || to) begin
        m_tmo    = to && !normal;
        m_ptr    = (m_holder + 1) % 16;
        m_holder = -1;
      end else begin
        m_hold++;
      end
    end
  endtask

  function automatic logic [0:15] onehot(input int idx);
    logic [0:15] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:15] bits2(input int a, input int b);
    logic [0:15] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, advance the model at the rising edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic [0:15] rq, input logic rl);
    @(negedge clk);
    reset = rst; req = rq; rel = rl;
    @(posedge clk);
    model_step(rst, rq, rl);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gnt_en"}, 32'(gnt_en), 32'(m_holder >= 0));
    check({tag, ".gnt_w"},  32'(gnt_w),  32'(m_w));
    check({tag, ".gnt"},    32'(gnt),    32'(onehot(m_holder)));
    check({tag, ".tmo"},    32'(tmo),    32'(m_tmo));
  endtask

  typedef struct {
    logic        rst;
    logic [0:15] rq;
    logic        rl;
    logic        en;
    logic [3:0]  w;
  } vec_t;

  vec_t tbl[29];

  initial begin
    reset = 1'b1; req = '0; rel = 1'b0;

    tbl[0]  = '{1'b1, bits2(-1, -1), 1'b0, 1'b0, 4'd0};   // reset
    tbl[1]  = '{1'b0, bits2(5, -1),  1'b0, 1'b1, 4'd5};
    tbl[2]  = '{1'b0, bits2(5, -1),  1'b1, 1'b0, 4'd5};   // release, ptr=6
    tbl[3]  = '{1'b1, bits2(-1, -1), 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd3};
    tbl[5]  = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd3};
    tbl[6]  = '{1'b0, bits2(3, 10),  1'b1, 1'b0, 4'd3};
    tbl[7]  = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd10};
    tbl[8]  = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd10};
    tbl[9]  = '{1'b0, bits2(3, 10),  1'b1, 1'b0, 4'd10};
    tbl[10] = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd3};
    tbl[11] = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd3};
    tbl[12] = '{1'b0, bits2(3, 10),  1'b1, 1'b0, 4'd3};
    tbl[13] = '{1'b0, bits2(3, 10),  1'b0, 1'b1, 4'd10};
    tbl[14] = '{1'b0, bits2(3, 10),  1'b1, 1'b0, 4'd10};  // one-cycle grant, ptr=11
    tbl[15] = '{1'b0, bits2(15, -1), 1'b0, 1'b1, 4'd15};
    tbl[16] = '{1'b0, bits2(15, -1), 1'b1, 1'b0, 4'd15};  // ptr wraps to 0
    tbl[17] = '{1'b0, bits2(0, 15),  1'b0, 1'b1, 4'd0};
    tbl[18] = '{1'b0, bits2(0, 15),  1'b1, 1'b0, 4'd0};   // ptr=1
    tbl[19] = '{1'b0, bits2(9, 12),  1'b0, 1'b1, 4'd9};
    tbl[20] = '{1'b0, bits2(12, -1), 1'b0, 1'b0, 4'd9};   // withdrawal of 9
    tbl[21] = '{1'b0, bits2(12, -1), 1'b0, 1'b1, 4'd12};
    tbl[22] = '{1'b0, bits2(12, -1), 1'b1, 1'b0, 4'd12};  // ptr=13
    tbl[23] = '{1'b0, bits2(4, -1),  1'b0, 1'b1, 4'd4};
    tbl[24] = '{1'b0, bits2(-1, -1), 1'b1, 1'b0, 4'd4};   // release + withdrawal, ptr=5
    tbl[25] = '{1'b0, bits2(2, 12),  1'b0, 1'b1, 4'd12};
    tbl[26] = '{1'b1, bits2(2, 12),  1'b0, 1'b0, 4'd0};   // reset mid-grant
    tbl[27] = '{1'b0, bits2(2, 12),  1'b0, 1'b1, 4'd2};
    tbl[28] = '{1'b0, bits2(2, 12),  1'b1, 1'b0, 4'd2};

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].rst, tbl[i].rq, tbl[i].rl);
      $display("vec %0d: rst=%0b req=%04h rel=%0b -> en=%0b w=%0d gnt=%04h tmo=%0b",
               i, tbl[i].rst, tbl[i].rq, tbl[i].rl, gnt_en, gnt_w, gnt, tmo);
      check($sformatf("vec%0d.gnt_en", i), 32'(gnt_en), 32'(tbl[i].en));
      check($sformatf("vec%0d.gnt_w", i),  32'(gnt_w),  32'(tbl[i].w));
      check($sformatf("vec%0d.gnt", i),    32'(gnt),    32'(tbl[i].en ? onehot(int'(tbl[i].w)) : 16'h0));
      check($sformatf("vec%0d.tmo", i),    32'(tmo),    32'd0);
    end

    // Requester 7 holds with no release: revoked after MAXH cycles when timeout is built in.
    step(1'b1, '0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      logic exp_en, exp_tmo;
      step(1'b0, bits2(7, -1), 1'b0);
      if (TO) begin
        exp_en  = (c % (MAXH + 1)) != MAXH;
        exp_tmo = (c % (MAXH + 1)) == MAXH;
      end else begin
        exp_en  = 1'b1;
        exp_tmo = 1'b0;
      end
      $display("hold %0d: en=%0b w=%0d tmo=%0b", c, gnt_en, gnt_w, tmo);
      check($sformatf("hold%0d.gnt_en", c), 32'(gnt_en), 32'(exp_en));
      check($sformatf("hold%0d.gnt_w", c),  32'(gnt_w),  32'd7);
      check($sformatf("hold%0d.tmo", c),    32'(tmo),    32'(exp_tmo));
    end

    // Random traffic against the model.
    step(1'b1, '0, 1'b0);
    check_model("rst");
    begin
      logic [0:15] rq;
      rq = '0;
      for (int n = 0; n < 3000; n++) begin
        logic rl, rs;
        for (int b = 0; b < 16; b++) begin
          if ($urandom_range(7) == 0) rq[b] = ~rq[b];
        end
        rl = ($urandom_range(3) == 0);
        rs = ($urandom_range(199) == 0);
        step(rs, rq, rl);
        $display("rnd %0d: rst=%0b req=%04h rel=%0b -> en=%0b w=%0d tmo=%0b",
                 n, rs, rq, rl, gnt_en, gnt_w, tmo);
        check_model($sformatf("rnd%0d", n));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
